systolic_mm_nxn: RTL and testbench

- Parametrised N x N output-stationary systolic matrix multiplier computing C = A x B over N x N operands.
- Successor to the fixed 3x3 PE grid; adds:
  - generic N, data width and accumulator width;
  - optional signed arithmetic;
  - internal input skewing;
  - start/valid/busy/done control FSM, so the host streams unskewed columns of A and rows of B.

---
 rtl/systolic_mm_nxn_if.sv | 25 ++
 rtl/systolic_mm_nxn.sv | 189 ++++++++++++++++++
 tb/tb_systolic_mm_nxn.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_mm_nxn_if.sv
// Host-side bus of the N x N systolic matrix multiplier: start/beat
// handshake, streamed operand columns/rows, status and the result matrix.
interface systolic_mm_nxn_if #(
    parameter int N      = 3,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
);
    logic                     start;
    logic                     in_valid;
    logic [N*DATA_W-1:0]      a_in;
    logic [N*DATA_W-1:0]      b_in;
    logic                     busy;
    logic                     done;
    logic [N*N*ACC_W-1:0]     c_out;

    modport master (
        output start, in_valid, a_in, b_in,
        input  busy, done, c_out
    );

    modport slave (
        input  start, in_valid, a_in, b_in,
        output busy, done, c_out
    );
endinterface

// File: rtl/systolic_mm_nxn.sv
// Output-stationary N x N systolic multiplier, C = A x B.  The host streams
// unskewed columns of A and rows of B; lanes are skewed internally so beat k
// meets PE(i,j) i+j cycles after acceptance.  A small FSM sequences
// IDLE -> LOAD -> DRAIN -> DONE.
module systolic_mm_nxn #(
    parameter int N      = 3,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18,
    parameter int SIGNED = 0
) (
    input logic              clk,
    input logic              reset,
    systolic_mm_nxn_if.slave bus
);

    localparam int SKEW_REGS  = N * (N - 1) / 2;
    localparam int DRAIN_LAST = 2 * N - 3;
    localparam int BEAT_W     = $clog2(N + 1);
    localparam int DRAIN_W    = $clog2(2 * N);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t               state, state_next;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 clear_all;
    logic                 take_beat;

    // Skew lanes are packed triangularly: lane i owns i stages starting here.
    function automatic int lane_base(input int lane);
        return lane * (lane - 1) / 2;
    endfunction

    // Full-width product, zero- or sign-extended to the accumulator width.
    function automatic logic [ACC_W-1:0] ext_prod(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] p;
        if (SIGNED != 0) begin
            p = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
            return ACC_W'($signed(p));
        end else begin
            p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
            return ACC_W'(p);
        end
    endfunction

    // Next-state logic and control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_next = state;
        clear_all  = 1'b0;
        take_beat  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    clear_all  = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    take_beat = 1'b1;
                    if (beat_cnt == BEAT_W'(N - 1)) state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_W'(DRAIN_LAST)) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);

    // State register plus beat and drain counters.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_next;
            if (clear_all)      beat_cnt <= '0;
            else if (take_beat) beat_cnt <= beat_cnt + 1'b1;
            if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
            else                  drain_cnt <= '0;
        end
    end

    logic [DATA_W-1:0] a_lane [N];
    logic [DATA_W-1:0] b_lane [N];
    logic [DATA_W-1:0] a_skew [SKEW_REGS];
    logic [DATA_W-1:0] b_skew [SKEW_REGS];
    logic [DATA_W-1:0] a_op   [N][N];
    logic [DATA_W-1:0] b_op   [N][N];
    logic [DATA_W-1:0] a_fwd  [N][N-1];
    logic [DATA_W-1:0] b_fwd  [N-1][N];
    logic [ACC_W-1:0]  acc    [N][N];

    // Gate the host lanes: anything but an accepted beat enters as zero.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_lane[i] = take_beat ? bus.a_in[i*DATA_W +: DATA_W] : '0;
            b_lane[i] = take_beat ? bus.b_in[i*DATA_W +: DATA_W] : '0;
        end
    end

    // Input skew: lane i is delayed by i stages before entering the array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || clear_all) begin
            // NOTE: these arrays are plain flops rather than RAM, so clearing
            // them on reset is cheap and keeps the array free of stale data.
            for (int s = 0; s < SKEW_REGS; s++) begin
                a_skew[s] <= '0;
                b_skew[s] <= '0;
            end
        end else begin
            for (int i = 1; i < N; i++) begin
                a_skew[lane_base(i)] <= a_lane[i];
                b_skew[lane_base(i)] <= b_lane[i];
                for (int s = 1; s < i; s++) begin
                    a_skew[lane_base(i) + s] <= a_skew[lane_base(i) + s - 1];
                    b_skew[lane_base(i) + s] <= b_skew[lane_base(i) + s - 1];
                end
            end
        end
    end

    // Operands seen by each PE: array edge from the skew, interior from neighbours.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_op[i][j] = '0;
                b_op[i][j] = '0;
            end
        end
        a_op[0][0] = a_lane[0];
        b_op[0][0] = b_lane[0];
        for (int i = 1; i < N; i++) begin
            a_op[i][0] = a_skew[lane_base(i) + i - 1];
            b_op[0][i] = b_skew[lane_base(i) + i - 1];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 1; j < N; j++) a_op[i][j] = a_fwd[i][j-1];
        end
        for (int i = 1; i < N; i++) begin
            for (int j = 0; j < N; j++) b_op[i][j] = b_fwd[i-1][j];
        end
    end

    // PE grid: accumulate a*b and pass a right, b down, one register each.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || clear_all) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) acc[i][j] <= '0;
                for (int j = 0; j < N - 1; j++) a_fwd[i][j] <= '0;
            end
            for (int i = 0; i < N - 1; i++) begin
                for (int j = 0; j < N; j++) b_fwd[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= acc[i][j] + ext_prod(a_op[i][j], b_op[i][j]);
                end
                for (int j = 0; j < N - 1; j++) a_fwd[i][j] <= a_op[i][j];
            end
            for (int i = 0; i < N - 1; i++) begin
                for (int j = 0; j < N; j++) b_fwd[i][j] <= b_op[i][j];
            end
        end
    end

    // Result bus driven straight from the accumulators.
    always_comb begin
        bus.c_out = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                bus.c_out[(i*N+j)*ACC_W +: ACC_W] = acc[i][j];
            end
        end
    end

endmodule

// File: tb/tb_systolic_mm_nxn.sv
// Directed bench for systolic_mm_nxn: N=3 unsigned and signed instances plus
// an N=4, DATA_W=4, ACC_W=10 instance, all against hand-derived results.
module tb_systolic_mm_nxn;

    typedef logic [7:0]  m3_t [3][3];
    typedef logic [17:0] c3_t [3][3];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    systolic_mm_nxn_if #(.N(3), .DATA_W(8), .ACC_W(18)) bus_u ();
    systolic_mm_nxn_if #(.N(3), .DATA_W(8), .ACC_W(18)) bus_s ();
    systolic_mm_nxn_if #(.N(4), .DATA_W(4), .ACC_W(10)) bus_p ();

    systolic_mm_nxn #(.N(3), .DATA_W(8), .ACC_W(18), .SIGNED(0)) u_uns (
        .clk(clk), .reset(reset), .bus(bus_u));
    systolic_mm_nxn #(.N(3), .DATA_W(8), .ACC_W(18), .SIGNED(1)) u_sgn (
        .clk(clk), .reset(reset), .bus(bus_s));
    systolic_mm_nxn #(.N(4), .DATA_W(4), .ACC_W(10), .SIGNED(0)) u_n4 (
        .clk(clk), .reset(reset), .bus(bus_p));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] col3(input m3_t a, input int k);
        logic [23:0] v;
        for (int i = 0; i < 3; i++) v[i*8 +: 8] = a[i][k];
        return v;
    endfunction

    function automatic logic [23:0] row3(input m3_t b, input int k);
        logic [23:0] v;
        for (int j = 0; j < 3; j++) v[j*8 +: 8] = b[k][j];
        return v;
    endfunction

    task automatic set_in(input bit sel, input logic st, input logic v,
                          input logic [23:0] a, input logic [23:0] b);
        if (sel) begin
            bus_s.start = st; bus_s.in_valid = v; bus_s.a_in = a; bus_s.b_in = b;
        end else begin
            bus_u.start = st; bus_u.in_valid = v; bus_u.a_in = a; bus_u.b_in = b;
        end
    endtask

    function automatic logic get_busy(input bit sel);
        return sel ? bus_s.busy : bus_u.busy;
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? bus_s.done : bus_u.done;
    endfunction

    function automatic logic [17:0] get_c(input bit sel, input int i, input int j);
        return sel ? bus_s.c_out[(i*3+j)*18 +: 18] : bus_u.c_out[(i*3+j)*18 +: 18];
    endfunction

    // One N=3 product. vpat bit idx is in_valid for load cycle idx (1 beyond vlen).
    // With poke set, start/in_valid are also pulsed in LOAD, DRAIN and DONE.
    task automatic run3(input string tag, input bit sel, input m3_t a, input m3_t b,
                        input logic [7:0] vpat, input int vlen, input bit poke,
                        input c3_t expc);
        int k, idx, n;
        bit got;
        logic v;
        set_in(sel, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        check({tag, "_busy_start_cycle"}, 64'(get_busy(sel)), 64'd0);
        @(posedge clk); #1;
        k = 0; idx = 0;
        while (k < 3 && idx < 16) begin
            v = (idx < vlen) ? vpat[idx] : 1'b1;
            set_in(sel, poke && idx == 1, v, col3(a, k), row3(b, k));
            @(negedge clk);
            check({tag, "_busy_load"}, 64'(get_busy(sel)), 64'd1);
            @(posedge clk); #1;
            if (v) k++;
            idx++;
        end
        got = 1'b0; n = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            set_in(sel, poke && c == 2, poke && c == 3, 24'hFFFFFF, 24'hFFFFFF);
            @(negedge clk);
            if (get_done(sel)) begin
                got = 1'b1; n = c;
            end else begin
                check({tag, "_busy_drain"}, 64'(get_busy(sel)), 64'd1);
                @(posedge clk); #1;
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_done_latency"}, 64'(n), 64'd5);
        check({tag, "_busy_at_done"}, 64'(get_busy(sel)), 64'd1);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                check($sformatf("%s_c%0d%0d", tag, i, j), 64'(get_c(sel, i, j)), 64'(expc[i][j]));
        set_in(sel, poke, 1'b0, '0, '0);
        @(posedge clk); #1;
        set_in(sel, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check({tag, "_done_pulse_end"}, 64'(get_done(sel)), 64'd0);
        check({tag, "_idle_after_done"}, 64'(get_busy(sel)), 64'd0);
        check({tag, "_c22_held"}, 64'(get_c(sel, 2, 2)), 64'(expc[2][2]));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    m3_t  ident, bmat, all255, neg1, two;
    c3_t  exp_b, exp_255, exp_neg6;
    int   n, e;
    bit   got;

    initial begin
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        set_in(1'b1, 1'b0, 1'b0, '0, '0);
        bus_p.start = 1'b0; bus_p.in_valid = 1'b0; bus_p.a_in = '0; bus_p.b_in = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ident[i][j]    = (i == j) ? 8'd1 : 8'd0;
                bmat[i][j]     = 8'(i * 3 + j + 1);
                all255[i][j]   = 8'd255;
                neg1[i][j]     = 8'hFF;
                two[i][j]      = 8'd2;
                exp_b[i][j]    = 18'(i * 3 + j + 1);
                exp_255[i][j]  = 18'h2FA03;
                exp_neg6[i][j] = 18'h3FFFA;
            end
        end

        // Reset state
        #12;
        check("rst_c_out_zero", 64'(|bus_u.c_out), 64'd0);
        check("rst_busy", 64'(bus_u.busy), 64'd0);
        check("rst_done", 64'(bus_u.done), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Identity x B, back to back
        run3("ident", 1'b0, ident, bmat, 8'h00, 0, 1'b0, exp_b);
        // All 255: largest unsigned sum, no wrap
        run3("max255", 1'b0, all255, all255, 8'h00, 0, 1'b0, exp_255);
        // Bubbles: in_valid pattern 1,0,0,1,0,1
        run3("bubble", 1'b0, ident, bmat, 8'b0010_1001, 6, 1'b0, exp_b);
        // Signed: -1 x 2 summed three times
        run3("signed", 1'b1, neg1, two, 8'h00, 0, 1'b0, exp_neg6);
        // Stray start / in_valid during LOAD, DRAIN and DONE
        run3("ctl", 1'b0, ident, bmat, 8'h00, 0, 1'b1, exp_b);

        // Reset in the middle of DRAIN
        set_in(1'b0, 1'b1, 1'b0, '0, '0);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 1'b0, 1'b1, col3(all255, k), row3(all255, k));
            @(posedge clk); #1;
        end
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_busy", 64'(bus_u.busy), 64'd1);
        reset = 1'b0;
        #1;
        check("midrst_busy", 64'(bus_u.busy), 64'd0);
        check("midrst_done", 64'(bus_u.done), 64'd0);
        check("midrst_c_out_zero", 64'(|bus_u.c_out), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run3("after_rst", 1'b0, ident, bmat, 8'h00, 0, 1'b0, exp_b);

        // N=4, DATA_W=4, ACC_W=10: A[i][k]=i+k, B[k][j]=k*j
        bus_p.start = 1'b1;
        @(posedge clk); #1;
        bus_p.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_p.in_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                bus_p.a_in[i*4 +: 4] = 4'(i + k);
                bus_p.b_in[i*4 +: 4] = 4'(k * i);
            end
            @(posedge clk); #1;
        end
        bus_p.in_valid = 1'b0;
        got = 1'b0; n = 0;
        for (int c = 1; c <= 30 && !got; c++) begin
            @(negedge clk);
            if (bus_p.done) begin
                got = 1'b1; n = c;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("n4_done_seen", 64'(got), 64'd1);
        check("n4_done_latency", 64'(n), 64'd7);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                e = 0;
                for (int k = 0; k < 4; k++) e += (i + k) * (k * j);
                check($sformatf("n4_c%0d%0d", i, j), 64'(bus_p.c_out[(i*4+j)*10 +: 10]), 64'(10'(e)));
            end
        end
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
